// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction bus, data bus and shared memory port seen by mem_arbiter.
// The slave modport is the arbiter's view; master is the core/memory side.
interface mem_arbiter_if;
  logic [19:1] instr_m_addr;
  logic [15:0] instr_m_data_in;
  logic        instr_m_access;
  logic        instr_m_ack;

  logic [19:1] data_m_addr;
  logic [15:0] data_m_data_in;
  logic [15:0] data_m_data_out;
  logic        data_m_access;
  logic        data_m_ack;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
  logic        d_io;

  logic [19:1] q_m_addr;
  logic [15:0] q_m_data_in;
  logic [15:0] q_m_data_out;
  logic        q_m_access;
  logic        q_m_ack;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic        q_m_io;

  modport slave (
    input  instr_m_addr, instr_m_access,
    input  data_m_addr, data_m_data_out, data_m_access, data_m_wr_en, data_m_bytesel, d_io,
    input  q_m_data_in, q_m_ack,
    output instr_m_data_in, instr_m_ack, data_m_data_in, data_m_ack,
    output q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel, q_m_io
  );

  modport master (
    output instr_m_addr, instr_m_access,
    output data_m_addr, data_m_data_out, data_m_access, data_m_wr_en, data_m_bytesel, d_io,
    output q_m_data_in, q_m_ack,
    input  instr_m_data_in, instr_m_ack, data_m_data_in, data_m_ack,
    input  q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel, q_m_io
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single memory port: data has priority, but a fetch
// that has watched STARVE_LIMIT consecutive data grants wins the next arbitration.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] run_cnt, run_cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      run_cnt <= '0;
    end else begin
      state   <= state_next;
      run_cnt <= run_cnt_next;
    end
  end

  // Only IDLE arbitrates; a grant is held until the memory acks, then RELEASE
  // gives the finished requester one cycle to drop its access line.
  always_comb begin
    state_next       = state;
    run_cnt_next     = run_cnt;
    bus.q_m_access   = 1'b0;
    bus.q_m_addr     = '0;
    bus.q_m_data_out = '0;
    bus.q_m_wr_en    = 1'b0;
    bus.q_m_bytesel  = 2'b00;
    bus.q_m_io       = 1'b0;
    bus.instr_m_ack  = 1'b0;
    bus.data_m_ack   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.instr_m_access && (!bus.data_m_access || run_cnt == CNT_MAX)) begin
          state_next   = GRANT_I;
          run_cnt_next = '0;
        end else if (bus.data_m_access) begin
          state_next = GRANT_D;
          if (bus.instr_m_access && run_cnt != CNT_MAX)
            run_cnt_next = run_cnt + CNT_W'(1);
        end
        if (!bus.instr_m_access)
          run_cnt_next = '0;
      end

      GRANT_I: begin
        bus.q_m_access  = 1'b1;
        bus.q_m_addr    = bus.instr_m_addr;
        bus.q_m_bytesel = 2'b11;
        bus.instr_m_ack = bus.q_m_ack;
        if (bus.q_m_ack)
          state_next = RELEASE;
      end

      GRANT_D: begin
        bus.q_m_access   = 1'b1;
        bus.q_m_addr     = bus.data_m_addr;
        bus.q_m_data_out = bus.data_m_data_out;
        bus.q_m_wr_en    = bus.data_m_wr_en;
        bus.q_m_bytesel  = bus.data_m_bytesel;
        bus.q_m_io       = bus.d_io;
        bus.data_m_ack   = bus.q_m_ack;
        if (bus.q_m_ack)
          state_next = RELEASE;
      end

      RELEASE: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  assign bus.instr_m_data_in = bus.q_m_data_in;
  assign bus.data_m_data_in  = bus.q_m_data_in;

  // A requester must keep its access line high for as long as it owns the port.
  instr_hold_a: assert property (@(posedge clk) disable iff (reset)
    (state == GRANT_I) |-> bus.instr_m_access);
  data_hold_a: assert property (@(posedge clk) disable iff (reset)
    (state == GRANT_D) |-> bus.data_m_access);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-by-cycle vector table for the basic
// transactions, then hand-built sequences for preemption, starvation and reset.
module tb_mem_arbiter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        i_acc;
    logic [19:1] i_addr;
    logic        d_acc;
    logic [19:1] d_addr;
    logic [15:0] d_out;
    logic        d_wr;
    logic [1:0]  d_bsel;
    logic        d_io;
    logic        q_ack;
    logic [15:0] q_din;
    logic        e_acc;
    logic [19:1] e_addr;
    logic [15:0] e_out;
    logic        e_wr;
    logic [1:0]  e_bsel;
    logic        e_io;
    logic        e_iack;
    logic        e_dack;
  } vec_t;

  localparam logic [19:1] IA   = 19'h00555;
  localparam logic [19:1] DA   = 19'h00666;
  localparam logic [15:0] DOUT = 16'h5A5A;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    reset               = v.rst;
    bus.instr_m_access  = v.i_acc;
    bus.instr_m_addr    = v.i_addr;
    bus.data_m_access   = v.d_acc;
    bus.data_m_addr     = v.d_addr;
    bus.data_m_data_out = v.d_out;
    bus.data_m_wr_en    = v.d_wr;
    bus.data_m_bytesel  = v.d_bsel;
    bus.d_io            = v.d_io;
    bus.q_m_ack         = v.q_ack;
    bus.q_m_data_in     = v.q_din;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    @(negedge clk);
    checkVal({tag, " q_m_access"},      32'(bus.q_m_access),      32'(v.e_acc));
    checkVal({tag, " q_m_addr"},        32'(bus.q_m_addr),        32'(v.e_addr));
    checkVal({tag, " q_m_data_out"},    32'(bus.q_m_data_out),    32'(v.e_out));
    checkVal({tag, " q_m_wr_en"},       32'(bus.q_m_wr_en),       32'(v.e_wr));
    checkVal({tag, " q_m_bytesel"},     32'(bus.q_m_bytesel),     32'(v.e_bsel));
    checkVal({tag, " q_m_io"},          32'(bus.q_m_io),          32'(v.e_io));
    checkVal({tag, " instr_m_ack"},     32'(bus.instr_m_ack),     32'(v.e_iack));
    checkVal({tag, " data_m_ack"},      32'(bus.data_m_ack),      32'(v.e_dack));
    checkVal({tag, " instr_m_data_in"}, 32'(bus.instr_m_data_in), 32'(v.q_din));
    checkVal({tag, " data_m_data_in"},  32'(bus.data_m_data_in),  32'(v.q_din));
  endtask

  task automatic runVec(input vec_t v, input string tag);
    applyStimulus(v);
    checkOutput(v, tag);
  endtask

  // One three-cycle transaction (IDLE, GRANT with ack, RELEASE) with both requesters held high.
  task automatic transact(input bit exp_instr, input bit idle_ack, input string tag);
    vec_t v;
    v = '{0, 1, IA, 1, DA, DOUT, 1, 2'b10, 0, idle_ack, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0};
    runVec(v, {tag, " idle"});
    if (exp_instr)
      v = '{0, 1, IA, 1, DA, DOUT, 1, 2'b10, 0, 1, 16'h55AA, 1, IA, 16'h0000, 0, 2'b11, 0, 1, 0};
    else
      v = '{0, 1, IA, 1, DA, DOUT, 1, 2'b10, 0, 1, 16'h55AA, 1, DA, DOUT, 1, 2'b10, 0, 0, 1};
    runVec(v, {tag, " grant"});
    v = '{0, 1, IA, 1, DA, DOUT, 1, 2'b10, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0};
    runVec(v, {tag, " release"});
  endtask

  vec_t table_v[20];
  vec_t v;

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.instr_m_access = 0; bus.instr_m_addr = 0;
    bus.data_m_access = 0;  bus.data_m_addr = 0; bus.data_m_data_out = 0;
    bus.data_m_wr_en = 0;   bus.data_m_bytesel = 0; bus.d_io = 0;
    bus.q_m_ack = 0;        bus.q_m_data_in = 0;

    // Fields: rst,i_acc,i_addr,d_acc,d_addr,d_out,d_wr,d_bsel,d_io,q_ack,q_din | acc,addr,out,wr,bsel,io,iack,dack
    table_v[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0};
    table_v[1]  = '{0, 1, 19'h00100, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0};
    table_v[2]  = '{0, 1, 19'h00100, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 19'h00100, 0, 0, 2'b11, 0, 0, 0};
    table_v[3]  = '{0, 1, 19'h00100, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 19'h00100, 0, 0, 2'b11, 0, 0, 0};
    table_v[4]  = '{0, 1, 19'h00100, 0, 0, 0, 0, 0, 0, 1, 16'h1234, 1, 19'h00100, 0, 0, 2'b11, 0, 1, 0};
    table_v[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h1234, 0, 0, 0, 0, 0, 0, 0, 0};
    table_v[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0};
    table_v[7]  = '{0, 0, 0, 1, 19'h40002, 16'hBEEF, 1, 2'b01, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0};
    table_v[8]  = '{0, 0, 0, 1, 19'h40002, 16'hBEEF, 1, 2'b01, 1, 0, 16'h0000, 1, 19'h40002, 16'hBEEF, 1, 2'b01, 1, 0, 0};
    table_v[9]  = '{0, 0, 0, 1, 19'h40002, 16'hBEEF, 1, 2'b01, 1, 1, 16'h0F0F, 1, 19'h40002, 16'hBEEF, 1, 2'b01, 1, 0, 1};
    table_v[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0};
    table_v[11] = '{0, 1, 19'h00200, 1, 19'h00300, 16'h0000, 0, 2'b11, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0};
    table_v[12] = '{0, 1, 19'h00200, 1, 19'h00300, 16'h0000, 0, 2'b11, 0, 0, 16'h0000, 1, 19'h00300, 0, 0, 2'b11, 0, 0, 0};
    table_v[13] = '{0, 1, 19'h00200, 1, 19'h00300, 16'h0000, 0, 2'b11, 0, 1, 16'h7777, 1, 19'h00300, 0, 0, 2'b11, 0, 0, 1};
    table_v[14] = '{0, 1, 19'h00200, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0};
    table_v[15] = '{0, 1, 19'h00200, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0};
    table_v[16] = '{0, 1, 19'h00200, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 19'h00200, 0, 0, 2'b11, 0, 0, 0};
    table_v[17] = '{0, 1, 19'h00200, 0, 0, 0, 0, 0, 0, 1, 16'hABCD, 1, 19'h00200, 0, 0, 2'b11, 0, 1, 0};
    table_v[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0};
    table_v[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0};

    repeat (2) @(posedge clk);
    for (int i = 0; i < 20; i++)
      runVec(table_v[i], $sformatf("row%0d", i));

    // A data request arriving mid-fetch must wait for the fetch ack plus RELEASE.
    v = '{0, 1, 19'h00AAA, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0};
    runVec(v, "preempt idle");
    v = '{0, 1, 19'h00AAA, 1, 19'h00BBB, 16'h1111, 1, 2'b01, 1, 0, 16'h0000, 1, 19'h00AAA, 0, 0, 2'b11, 0, 0, 0};
    runVec(v, "preempt hold1");
    runVec(v, "preempt hold2");
    v = '{0, 1, 19'h00AAA, 1, 19'h00BBB, 16'h1111, 1, 2'b01, 1, 1, 16'h2222, 1, 19'h00AAA, 0, 0, 2'b11, 0, 1, 0};
    runVec(v, "preempt iack");
    v = '{0, 0, 0, 1, 19'h00BBB, 16'h1111, 1, 2'b01, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0};
    runVec(v, "preempt release");
    runVec(v, "preempt rearb");
    v = '{0, 0, 0, 1, 19'h00BBB, 16'h1111, 1, 2'b01, 1, 0, 16'h0000, 1, 19'h00BBB, 16'h1111, 1, 2'b01, 1, 0, 0};
    runVec(v, "preempt dgrant");
    v = '{0, 0, 0, 1, 19'h00BBB, 16'h1111, 1, 2'b01, 1, 1, 16'h3333, 1, 19'h00BBB, 16'h1111, 1, 2'b01, 1, 0, 1};
    runVec(v, "preempt dack");
    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0};
    runVec(v, "preempt done");

    // Both requesters held high: four data grants, then the fetch, then data again.
    for (int k = 0; k < 4; k++)
      transact(1'b0, 1'b0, $sformatf("starve d%0d", k));
    transact(1'b1, 1'b0, "starve i");
    for (int k = 0; k < 3; k++)
      transact(1'b0, 1'b0, $sformatf("refill d%0d", k));

    // Fourth data grant aborted by reset; the starvation count must restart from zero.
    v = '{0, 1, IA, 1, DA, DOUT, 1, 2'b10, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0};
    runVec(v, "abort idle");
    v = '{0, 1, IA, 1, DA, DOUT, 1, 2'b10, 0, 0, 16'h0000, 1, DA, DOUT, 1, 2'b10, 0, 0, 0};
    runVec(v, "abort grant");
    v = '{1, 1, IA, 1, DA, DOUT, 1, 2'b10, 0, 0, 16'h0000, 1, DA, DOUT, 1, 2'b10, 0, 0, 0};
    runVec(v, "abort reset");
    transact(1'b0, 1'b1, "post d0");
    for (int k = 1; k < 4; k++)
      transact(1'b0, 1'b0, $sformatf("post d%0d", k));
    transact(1'b1, 1'b0, "post i");

    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0};
    runVec(v, "final idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
